// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel, core redirect,
// and the valid/ready instruction stream handed to decode.
interface fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd;
    logic [31:0] cmd_pc;

    modport master (
        output imem_req, imem_addr, cmd_valid, cmd, cmd_pc,
        input  imem_ack, imem_data, redirect, redirect_pc, cmd_ready
    );

    modport slave (
        input  imem_req, imem_addr, cmd_valid, cmd, cmd_pc,
        output imem_ack, imem_data, redirect, redirect_pc, cmd_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, requests words from imem, buffers
// {pc, word} pairs in a small FIFO and flushes/restarts on core redirects.
//
// state | meaning
// RUN   | normal fetch at fetch_pc while the FIFO has room
// DRAIN | a redirect hit a pending request; hold drain_addr until acked, drop data
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    rst,
    fetch_if.master bus
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic {RUN, DRAIN} state_e;

    state_e          state_q;
    logic [31:0]     fetch_pc_q;
    logic [31:0]     drain_addr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     data_mem_q [DEPTH];

    logic req;
    logic xfer;
    logic push;
    logic pop;
    logic valid;

    always_comb begin
        req   = !rst && ((state_q == DRAIN) || (count_q != FULL_CNT));
        xfer  = req && bus.imem_ack;
        push  = xfer && (state_q == RUN) && !bus.redirect;
        valid = !rst && (count_q != '0);
        pop   = valid && bus.cmd_ready;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;
    assign bus.cmd_valid = valid;
    assign bus.cmd       = valid ? data_mem_q[rd_ptr_q] : '0;
    assign bus.cmd_pc    = valid ? pc_mem_q[rd_ptr_q]   : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= bus.imem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= '0;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
        end else if (bus.redirect) begin
            // Redirect wins over push/pop; a pending un-acked request must still complete.
            fetch_pc_q <= bus.redirect_pc & ~32'd3;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            case (state_q)
                RUN: begin
                    if (req && !bus.imem_ack) begin
                        drain_addr_q <= fetch_pc_q;
                        state_q      <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.imem_ack) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end else begin
            if ((state_q == DRAIN) && bus.imem_ack) begin
                state_q <= RUN;
            end
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + 1'b1;
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with a latency-programmable memory
// model, an expected-instruction queue and a monitor that checks every pop.
module tb_fetch_unit;
    logic clk;
    logic rst;

    fetch_if bus ();

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q [$];
    logic [31:0] xlog  [$];

    logic en;
    int   ack_delay;
    int   wc;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_5A5A;
    endfunction

    // Memory model: acks once the request has been waiting ack_delay cycles.
    always @(posedge clk) begin
        if (rst || !bus.imem_req || bus.imem_ack) wc <= 0;
        else wc <= wc + 1;
    end
    assign bus.imem_ack  = en && bus.imem_req && (wc >= ack_delay);
    assign bus.imem_data = data_of(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] pc);
        exp_q.push_back({pc, data_of(pc)});
    endtask

    // Monitor: logs every transfer and scores every pop against the queue.
    always @(negedge clk) begin
        logic [63:0] e;
        if (bus.imem_req && bus.imem_ack) xlog.push_back(bus.imem_addr);
        if (bus.cmd_valid && bus.cmd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop actual_pc=%h required=none", bus.cmd_pc);
            end else begin
                e = exp_q.pop_front();
                check("cmd_pc", bus.cmd_pc, e[63:32]);
                check("cmd", bus.cmd, e[31:0]);
            end
        end
    end

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 200 && xlog.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        check(name, 32'(xlog.size()), 32'(n));
    endtask

    task automatic do_reset(input int d, input logic r);
        rst = 1'b1;
        en = 1'b1;
        ack_delay = d;
        bus.cmd_ready = r;
        bus.redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        xlog.delete();
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        ack_delay = 0;
        bus.redirect = 1'b0;
        bus.redirect_pc = '0;
        bus.cmd_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, bus.cmd_valid}, 32'd0);
        check("rst_cmd", bus.cmd, 32'd0);
        check("rst_cmd_pc", bus.cmd_pc, 32'd0);

        // Streaming: always ack, always ready
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) expect_instr(32'(4 * i));
        ack_delay = 0;
        bus.cmd_ready = 1'b1;
        en = 1'b1;
        rst = 1'b0;
        xlog.delete();
        @(negedge clk);
        check("t1_addr0_pending", bus.imem_addr, 32'd0);
        @(negedge clk);
        check("t1_first_valid", {31'b0, bus.cmd_valid}, 32'd1);
        wait_log(8, "t1_xfers");
        en = 1'b0;
        for (int i = 0; i < 8; i++) check("t1_addr", xlog[i], 32'(4 * i));
        repeat (3) @(posedge clk);
        #1;

        // Fill to DEPTH with core stalled, then release
        for (int i = 0; i < 4; i++) expect_instr(32'(4 * i));
        do_reset(0, 1'b0);
        wait_log(4, "t2_fill");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t2_full_req", {31'b0, bus.imem_req}, 32'd0);
        check("t2_full_valid", {31'b0, bus.cmd_valid}, 32'd1);
        check("t2_xfer_count", 32'(xlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t2_addr", xlog[i], 32'(4 * i));
        @(posedge clk);
        #1;
        bus.cmd_ready = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        @(negedge clk);
        check("t2_rereq", {31'b0, bus.imem_req}, 32'd1);
        check("t2_rereq_addr", bus.imem_addr, 32'h10);
        repeat (6) @(posedge clk);
        #1;

        // Redirect while a slow request is pending -> DRAIN
        expect_instr(32'h0);
        expect_instr(32'h4);
        expect_instr(32'h40);
        do_reset(3, 1'b1);
        wait_log(2, "t3_first_two");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h40;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("t3_hold_req", {31'b0, bus.imem_req}, 32'd1);
        check("t3_hold_addr", bus.imem_addr, 32'h8);
        wait_log(4, "t3_xfers");
        en = 1'b0;
        check("t3_drained", xlog[2], 32'h8);
        check("t3_restart", xlog[3], 32'h40);
        repeat (4) @(posedge clk);
        #1;

        // Redirect coinciding with an ack, two entries buffered
        do_reset(0, 1'b0);
        wait_log(2, "t4_two_buffered");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h103;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("t4_flush_valid", {31'b0, bus.cmd_valid}, 32'd0);
        check("t4_req", {31'b0, bus.imem_req}, 32'd1);
        check("t4_next_addr", bus.imem_addr, 32'h100);
        check("t4_acked_addr", xlog[2], 32'h8);
        @(posedge clk);
        #1;
        expect_instr(32'h100);
        bus.cmd_ready = 1'b1;
        en = 1'b1;
        wait_log(4, "t4_restart_xfer");
        en = 1'b0;
        check("t4_restart", xlog[3], 32'h100);
        repeat (3) @(posedge clk);
        #1;

        // Two redirects inside one DRAIN
        expect_instr(32'h0);
        expect_instr(32'hC0);
        do_reset(3, 1'b1);
        wait_log(1, "t5_first");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h80;
        @(posedge clk);
        #1;
        bus.redirect_pc = 32'hC0;
        @(posedge clk);
        #1;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("t5_drain_addr", bus.imem_addr, 32'h4);
        wait_log(3, "t5_xfers");
        en = 1'b0;
        check("t5_drained", xlog[1], 32'h4);
        check("t5_restart", xlog[2], 32'hC0);
        repeat (4) @(posedge clk);
        #1;

        // Reset with a pending request and three entries buffered
        do_reset(0, 1'b0);
        wait_log(3, "t6_three_buffered");
        en = 1'b0;
        @(negedge clk);
        check("t6_pending_addr", bus.imem_addr, 32'hC);
        check("t6_pre_valid", {31'b0, bus.cmd_valid}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_req", {31'b0, bus.imem_req}, 32'd0);
        check("t6_rst_valid", {31'b0, bus.cmd_valid}, 32'd0);
        check("t6_rst_cmd", bus.cmd, 32'd0);
        check("t6_rst_cmd_pc", bus.cmd_pc, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_req", {31'b0, bus.imem_req}, 32'd1);
        check("t6_post_addr", bus.imem_addr, 32'h0);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle processor core. It owns the fetch PC and issues word requests to an instruction memory over a req/ack handshake. Returned words are buffered with their PCs in a small FIFO and presented to decode over a valid/ready interface. Branch and jump redirects from the core flush the buffer and restart fetch at the new PC, with a request already in flight drained safely.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
imem_req  output  1  fetch request to instruction memory
imem_addr  output  32  word address of the request; bits [1:0] always 0
imem_ack  input  1  memory accepts the request and returns imem_data in the same cycle
imem_data  input  32  instruction word, valid when imem_req && imem_ack
redirect  input  1  core branch/jump taken (BEQ/BNE/JAL/JR)
redirect_pc  input  32  target PC; bits [1:0] are ignored and forced to 0
cmd_valid  output  1  FIFO head holds a valid instruction
cmd_ready  input  1  core consumes the head this cycle
cmd  output  32  head instruction; 0 when cmd_valid=0
cmd_pc  output  32  PC of the head instruction; 0 when cmd_valid=0

Behaviour:
- Reset (rst=1 at an edge): fetch_pc<=RESET_PC, count<=0, state<=RUN, rd/wr pointers<=0.
  - While in reset: imem_req=0, cmd_valid=0, cmd=0, cmd_pc=0.
  - Reset mid-request abandons that request. The memory model also resets.
- Handshake: a transfer occurs at an edge where imem_req && imem_ack.
  - Once asserted, imem_req stays high with imem_addr stable until ack.
  - imem_ack while imem_req=0 is ignored.
  - At most one request is outstanding.
- State RUN:
  - imem_req = (count<DEPTH); imem_addr = fetch_pc.
  - On transfer with no redirect: push {fetch_pc, imem_data}; fetch_pc<=fetch_pc+4 (32-bit wrap at 32'hFFFF_FFFC -> 0).
  - Back-to-back transfers every cycle are allowed.
- State DRAIN:
  - imem_req=1; imem_addr=drain_addr.
  - On ack: data discarded, state<=RUN. The next request in RUN uses fetch_pc.
- Redirect (redirect=1 at an edge) has priority over push and pop:
  - FIFO flushed (count<=0, pointers<=0); fetch_pc<=redirect_pc & ~3.
  - In RUN with imem_req=1 and imem_ack=0: drain_addr<=old fetch_pc, state<=DRAIN.
  - In RUN with ack the same cycle, or imem_req=0: acked data discarded, stay RUN.
  - In DRAIN without ack: stay DRAIN, drain_addr unchanged, fetch_pc takes the newest target.
  - In DRAIN with ack: state<=RUN.
  - A pop in the redirect cycle is still taken by the core; cmd_valid=0 in the following cycle.
- Output side:
  - cmd_valid=(count!=0); cmd/cmd_pc come from the head entry.
  - Pop when cmd_valid && cmd_ready. cmd_ready with an empty FIFO has no effect.
  - Push and pop in the same cycle leave count unchanged.
  - Push never occurs at count=DEPTH, because imem_req=0 when full.
- Latency: a transfer at edge N with an empty FIFO gives cmd_valid=1 after edge N. There is no combinational bypass from imem_data to cmd.
- Order: instructions leave in fetch order. cmd_pc of consecutive entries differs by 4 unless separated by a redirect.

Test Plan:
- Reset, then memory always acks, cmd_ready=1 -> imem_addr=0,4,8,... one per cycle; cmd/cmd_pc stream starts 1 cycle after the first ack with cmd_pc=0,4,8.
- cmd_ready=0, DEPTH=4, always-ack -> exactly 4 transfers (addr 0..12), then imem_req=0 and count=4; raise cmd_ready -> one pop per cycle, imem_req reasserts at addr 16.
- Memory acks 3 cycles after req; redirect to 0x40 while the request to 0x8 is pending -> imem_addr held at 0x8 until ack, that data is dropped, next imem_addr=0x40, first cmd_pc=0x40.
- Redirect to 0x103 with an ack in the same cycle and 2 entries buffered -> the acked word and both entries are discarded, cmd_valid=0 next cycle, next imem_addr=0x100.
- Two redirects (0x80, then 0xC0) during one DRAIN -> single drained ack, then fetch resumes at 0xC0; no cmd_pc of 0x80 is ever presented.
- Assert rst while a request is pending and 3 entries are buffered -> next cycle imem_req=0, cmd_valid=0; after rst drops, imem_addr=RESET_PC.
